float_mul_pipe: RTL and testbench

Pipelined, parametrised floating-point multiplier with a valid/ready handshake on both sides, for the matmul datapath. It replaces the combinational multiplier in timing-critical paths. It adds round-to-nearest-even, IEEE invalid-operation handling (inf × 0), flush-to-zero of subnormals, and a sideband tag that travels with each operation. It sits between the operand fetch and the accumulator adder stages.

---
 rtl/float_mul_pipe_pkg.sv | 28 ++
 rtl/float_round_norm.sv | 77 +++++++
 rtl/float_mul_pipe.sv | 120 ++++++++++++
 tb/tb_float_mul_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/float_mul_pipe_pkg.sv
// Shared definitions for the pipelined floating-point multiplier: result flag
// positions, operand classes and the operand classification helper.
package float_mul_pipe_pkg;

  localparam int FLAG_W       = 4;
  localparam int FLAG_INVALID = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT = 0;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_NORMAL = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } cls_e;

  // Subnormals (exp == 0) are flushed, so they classify as zero.
  function automatic cls_e classify(input logic exp_zero, input logic exp_ones,
                                    input logic man_zero);
    if (exp_zero)
      return CLS_ZERO;
    if (!exp_ones)
      return CLS_NORMAL;
    return man_zero ? CLS_INF : CLS_NAN;
  endfunction

endpackage

// File: rtl/float_round_norm.sv
// Combinational back end of a float datapath: normalise a raw mantissa product,
// round to nearest-even, select special/exception results and pack.
module float_round_norm
  import float_mul_pipe_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                           sign_i,
  input  logic [1:0]                     cls_l_i,
  input  logic [1:0]                     cls_r_i,
  input  logic [2*MAN_WIDTH+1:0]         prod_i,
  input  logic signed [EXP_WIDTH+1:0]    exp_i,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   res_o,
  output logic [FLAG_W-1:0]              flags_o
);

  localparam int PW = 2*MAN_WIDTH + 2;
  localparam int EW = EXP_WIDTH + 2;
  localparam logic [EXP_WIDTH-1:0]  EXP_ONES = '1;
  localparam logic [MAN_WIDTH-1:0]  MAN_ONES = '1;
  localparam logic [MAN_WIDTH-1:0]  MAN_ZERO = '0;
  localparam logic [EXP_WIDTH+MAN_WIDTH-1:0] MAG_ZERO = '0;
  localparam logic signed [EW-1:0]  EXP_MAX  = EW'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EW-1:0]  EXP_ZERO = '0;

  cls_e                  cls_l, cls_r;
  logic [PW-1:0]         norm;
  logic [MAN_WIDTH:0]    mant;
  logic                  guard, sticky, round_up;
  logic [MAN_WIDTH+1:0]  mant_r;
  logic [MAN_WIDTH-1:0]  man_out;
  logic signed [EW-1:0]  exp_n, exp_f;
  logic                  any_nan, any_inf, any_zero;

  always_comb begin
    cls_l    = cls_e'(cls_l_i);
    cls_r    = cls_e'(cls_r_i);
    // A product of two [1,2) mantissas lies in [1,4); align so the leading one sits at the top.
    norm     = prod_i[PW-1] ? prod_i : {prod_i[PW-2:0], 1'b0};
    exp_n    = exp_i + {{(EW-1){1'b0}}, prod_i[PW-1]};
    mant     = norm[PW-1:MAN_WIDTH+1];
    guard    = norm[MAN_WIDTH];
    sticky   = |norm[MAN_WIDTH-1:0];
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {{(MAN_WIDTH+1){1'b0}}, round_up};
    man_out  = mant_r[MAN_WIDTH+1] ? mant_r[MAN_WIDTH:1] : mant_r[MAN_WIDTH-1:0];
    exp_f    = exp_n + {{(EW-1){1'b0}}, mant_r[MAN_WIDTH+1]};
    any_nan  = (cls_l == CLS_NAN) || (cls_r == CLS_NAN);
    any_inf  = (cls_l == CLS_INF) || (cls_r == CLS_INF);
    any_zero = (cls_l == CLS_ZERO) || (cls_r == CLS_ZERO);
  end

  always_comb begin
    res_o   = {sign_i, exp_f[EXP_WIDTH-1:0], man_out};
    flags_o = '0;
    if (any_nan || (any_inf && any_zero)) begin
      res_o                 = {1'b0, EXP_ONES, MAN_ONES};
      flags_o[FLAG_INVALID] = 1'b1;
    end else if (any_inf) begin
      res_o = {sign_i, EXP_ONES, MAN_ZERO};
    end else if (any_zero) begin
      res_o = {sign_i, MAG_ZERO};
    end else if (exp_f >= EXP_MAX) begin
      res_o                  = {sign_i, EXP_ONES, MAN_ZERO};
      flags_o[FLAG_OVERFLOW] = 1'b1;
      flags_o[FLAG_INEXACT]  = 1'b1;
    end else if (exp_f <= EXP_ZERO) begin
      res_o                   = {sign_i, MAG_ZERO};
      flags_o[FLAG_UNDERFLOW] = 1'b1;
      flags_o[FLAG_INEXACT]   = 1'b1;
    end else begin
      flags_o[FLAG_INEXACT] = guard | sticky;
    end
  end

endmodule

// File: rtl/float_mul_pipe.sv
// Three-stage floating-point multiplier with valid/ready on both sides and a
// sideband tag; a single advance enable moves or freezes the whole pipeline.
module float_mul_pipe
  import float_mul_pipe_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int BIAS      = (1 << (EXP_WIDTH-1)) - 1,
  parameter int TAG_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_lhs,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_rhs,
  input  logic [TAG_WIDTH-1:0]           in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   out_res,
  output logic [TAG_WIDTH-1:0]           out_tag,
  output logic [FLAG_W-1:0]              out_flags
);

  localparam int W  = EXP_WIDTH + MAN_WIDTH + 1;
  localparam int EW = EXP_WIDTH + 2;
  localparam int PW = 2*MAN_WIDTH + 2;

  logic adv;

  // S1: classified, unpacked operands
  logic                  v1_q, sign1_q;
  logic [TAG_WIDTH-1:0]  tag1_q;
  logic [1:0]            cls_l1_q, cls_r1_q, cls_l_d, cls_r_d;
  logic [MAN_WIDTH:0]    man_l1_q, man_r1_q;
  logic [EXP_WIDTH-1:0]  exp_l1_q, exp_r1_q;

  // S2: raw product and biased exponent sum
  logic                  v2_q, sign2_q;
  logic [TAG_WIDTH-1:0]  tag2_q;
  logic [1:0]            cls_l2_q, cls_r2_q;
  logic [PW-1:0]         prod2_q, prod_d;
  logic signed [EW-1:0]  exp2_q, exp_d;

  // S3: output register
  logic                  out_valid_q;
  logic [W-1:0]          out_res_q, res_d;
  logic [TAG_WIDTH-1:0]  out_tag_q;
  logic [FLAG_W-1:0]     out_flags_q, flags_d;

  assign adv      = !out_valid_q | out_ready;
  assign in_ready = adv;

  always_comb begin
    cls_l_d = classify(in_lhs[W-2:MAN_WIDTH] == '0, &in_lhs[W-2:MAN_WIDTH],
                       in_lhs[MAN_WIDTH-1:0] == '0);
    cls_r_d = classify(in_rhs[W-2:MAN_WIDTH] == '0, &in_rhs[W-2:MAN_WIDTH],
                       in_rhs[MAN_WIDTH-1:0] == '0);
    prod_d  = {{(MAN_WIDTH+1){1'b0}}, man_l1_q} * {{(MAN_WIDTH+1){1'b0}}, man_r1_q};
    exp_d   = $signed({2'b00, exp_l1_q}) + $signed({2'b00, exp_r1_q}) - EW'(BIAS);
  end

  float_round_norm #(
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH)
  ) u_round_norm (
    .sign_i  (sign2_q),
    .cls_l_i (cls_l2_q),
    .cls_r_i (cls_r2_q),
    .prod_i  (prod2_q),
    .exp_i   (exp2_q),
    .res_o   (res_d),
    .flags_o (flags_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
      out_flags_q <= '0;
    end else if (adv) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      out_res_q   <= res_d;
      out_tag_q   <= tag2_q;
      out_flags_q <= flags_d;
    end
  end

  // NOTE: inner stage payloads have no reset; only the valid bits qualify them,
  // so resetting the wide datapath would buy nothing.
  always_ff @(posedge clk) begin
    if (adv) begin
      sign1_q  <= in_lhs[W-1] ^ in_rhs[W-1];
      tag1_q   <= in_tag;
      cls_l1_q <= cls_l_d;
      cls_r1_q <= cls_r_d;
      man_l1_q <= {1'b1, in_lhs[MAN_WIDTH-1:0]};
      man_r1_q <= {1'b1, in_rhs[MAN_WIDTH-1:0]};
      exp_l1_q <= in_lhs[W-2:MAN_WIDTH];
      exp_r1_q <= in_rhs[W-2:MAN_WIDTH];
      sign2_q  <= sign1_q;
      tag2_q   <= tag1_q;
      cls_l2_q <= cls_l1_q;
      cls_r2_q <= cls_r1_q;
      prod2_q  <= prod_d;
      exp2_q   <= exp_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_tag   = out_tag_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_float_mul_pipe.sv
// Self-checking bench for float_mul_pipe (fp32 defaults): directed special cases,
// randomized backpressure streams against an arithmetic model, and mid-stream reset.
module tb_float_mul_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_lhs, in_rhs, out_res;
  logic [3:0]  in_tag, out_tag, out_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  float_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lhs    (in_lhs),
    .in_rhs    (in_rhs),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, then round by comparing the discarded
  // remainder against one half. Returns {flags, result}.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, e, sh;
    longint ma, mb, p, keep, rem, half;
    bit     s, za, zb, ia, ib, na, nb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    if (na || nb || (ia && zb) || (ib && za)) return {4'b1000, 32'h7FFF_FFFF};
    if (ia || ib) return {4'b0000, s, 8'hFF, 23'h0};
    if (za || zb) return {4'b0000, s, 31'h0};
    ma = longint'(a[22:0]) + (64'sd1 << 23);
    mb = longint'(b[22:0]) + (64'sd1 << 23);
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= (64'sd1 << 47)) begin
      sh = 24;
      e++;
    end else begin
      sh = 23;
    end
    keep = p >> sh;
    rem  = p - (keep << sh);
    half = 64'sd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep++;
    if (keep == (64'sd1 << 24)) begin
      keep = keep >> 1;
      e++;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0)   return {4'b0011, s, 31'h0};
    return {3'b000, rem != 0, s, 8'(e), keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  ex;
    logic [22:0] mn;
    ex = 8'($urandom_range(0, 255));
    case ($urandom_range(0, 7))
      0:       ex = 8'h00;
      1:       ex = 8'hFF;
      default: ;
    endcase
    mn = 23'($urandom);
    if ($urandom_range(0, 3) == 0) mn = '0;
    return {1'($urandom), ex, mn};
  endfunction

  // Single op with an always-ready consumer: checks result, flags, tag and latency.
  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [3:0] exp_flags,
                         input logic [3:0] tag);
    int n;
    out_ready = 1'b1;
    in_lhs    = a;
    in_rhs    = b;
    in_tag    = tag;
    in_valid  = 1'b1;
    check({name, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, n, 3);
    check({name, "_res"}, out_res, exp_res);
    check({name, "_flags"}, out_flags, exp_flags);
    check({name, "_tag"}, out_tag, tag);
    @(posedge clk);
    #1;
  endtask

  // Random valid/ready traffic; expected results are queued at accept time.
  task automatic stream(input string name, input int n_ops, input int budget);
    logic [35:0] q[$];
    logic [3:0]  tq[$];
    logic [35:0] held_v;
    logic [3:0]  held_t;
    logic [35:0] e;
    int          sent, got, cyc;
    bit          held;
    sent = 0;
    got  = 0;
    cyc  = 0;
    held = 1'b0;
    held_v = '0;
    held_t = '0;
    while ((sent < n_ops || q.size() > 0) && cyc < budget) begin
      in_valid  = (sent < n_ops) && ($urandom_range(0, 3) != 0);
      in_lhs    = rand_op();
      in_rhs    = rand_op();
      in_tag    = 4'(sent);
      out_ready = 1'($urandom);
      @(negedge clk);
      if (held) begin
        check({name, "_hold_valid"}, out_valid, 1);
        check({name, "_hold_data"}, {out_flags, out_res, out_tag}, {held_v, held_t});
      end
      held   = out_valid && !out_ready;
      held_v = {out_flags, out_res};
      held_t = out_tag;
      if (out_valid && out_ready) begin
        check({name, "_no_spurious"}, q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check({name, "_res"}, {out_flags, out_res}, e);
          check({name, "_tag"}, out_tag, tq.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_mul(in_lhs, in_rhs));
        tq.push_back(4'(sent));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_count"}, got, n_ops);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d_a   [13] = '{32'h4000_0000, 32'h3F80_0001, 32'h3F80_0001, 32'h7F80_0000,
                              32'hFF80_0000, 32'h7FC0_0000, 32'h7F00_0000, 32'h8080_0000,
                              32'h0000_0001, 32'h3FFF_FFFF, 32'h7F7F_FFFF, 32'h7F7F_FFFF,
                              32'h0080_0000};
  logic [31:0] d_b   [13] = '{32'h4040_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'h0000_0000,
                              32'h4000_0000, 32'h3F80_0000, 32'h7F00_0000, 32'h0080_0000,
                              32'h3F80_0000, 32'h3FFF_FFFF, 32'h4000_0000, 32'h3F80_0000,
                              32'h3F00_0000};
  logic [31:0] d_res [13] = '{32'h40C0_0000, 32'h3FC0_0002, 32'h3F80_0002, 32'h7FFF_FFFF,
                              32'hFF80_0000, 32'h7FFF_FFFF, 32'h7F80_0000, 32'h8000_0000,
                              32'h0000_0000, 32'h407F_FFFE, 32'h7F80_0000, 32'h7F7F_FFFF,
                              32'h0000_0000};
  logic [3:0]  d_fl  [13] = '{4'b0000, 4'b0001, 4'b0001, 4'b1000,
                              4'b0000, 4'b1000, 4'b0101, 4'b0011,
                              4'b0000, 4'b0001, 4'b0101, 4'b0000,
                              4'b0011};

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_lhs    = '0;
    in_rhs    = '0;
    in_tag    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 13; i++)
      run_one($sformatf("dir%0d", i), d_a[i], d_b[i], d_res[i], d_fl[i], 4'(i));

    stream("bp8", 8, 400);
    stream("rand", 200, 4000);

    // Three ops in flight with the output stalled, then a one-cycle reset.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_lhs   = 32'h4000_0000;
      in_rhs   = 32'h4040_0000;
      in_tag   = 4'(i + 9);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("stall_out_valid", out_valid, 1);
    check("stall_in_ready", in_ready, 0);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_res", out_res, 0);
    check("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("mid_rst_flushed", seen, 0);
    run_one("post_rst", 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'b0000, 4'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
